// File: rtl/simt_reconv_stack_if.sv
// Core <-> reconvergence-stack bus: branch outcomes and retire events in,
// active mask, PC redirects, stall and stack status out.
interface simt_reconv_stack_if #(
    parameter int NUM_THREADS = 4,
    parameter int PC_WIDTH    = 16,
    parameter int STACK_DEPTH = 8
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                   br_valid;
    logic [NUM_THREADS-1:0] br_taken;
    logic [PC_WIDTH-1:0]    br_target;
    logic [PC_WIDTH-1:0]    br_fallthru;
    logic [PC_WIDTH-1:0]    br_reconv;
    logic                   pc_valid;
    logic [PC_WIDTH-1:0]    next_pc;
    logic [NUM_THREADS-1:0] active_mask;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   stall;
    logic [DEPTH_W-1:0]     depth;
    logic                   overflow;

    modport master (
        output br_valid, br_taken, br_target, br_fallthru, br_reconv,
        output pc_valid, next_pc,
        input  active_mask, redirect_valid, redirect_pc, stall, depth, overflow
    );

    modport slave (
        input  br_valid, br_taken, br_target, br_fallthru, br_reconv,
        input  pc_valid, next_pc,
        output active_mask, redirect_valid, redirect_pc, stall, depth, overflow
    );
endinterface

// File: rtl/simt_reconv_stack.sv
// SIMT divergence/reconvergence unit: active mask plus a {pc, mask, rpc} stack
// that serialises divergent paths and reconverges at the post-dominator PC.
module simt_reconv_stack #(
    parameter int NUM_THREADS = 4,
    parameter int PC_WIDTH    = 16,
    parameter int STACK_DEPTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    simt_reconv_stack_if.slave bus
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [NUM_THREADS-1:0] mask;
        logic [PC_WIDTH-1:0]    rpc;
    } entry_t;

    typedef enum logic {S_RUN, S_CHAIN} state_t;

    entry_t                 stack_q [STACK_DEPTH];
    state_t                 state_q, state_d;
    logic [NUM_THREADS-1:0] mask_q, mask_d;
    logic [PC_WIDTH-1:0]    rpc_q, rpc_d;
    logic [PC_WIDTH-1:0]    redir_pc_q, redir_pc_d;
    logic [DW-1:0]          depth_q, depth_d;
    logic                   redir_q, redir_d;
    logic                   ovf_q, ovf_d;
    logic                   push_lo, push_hi, do_pop;
    logic                   divergent, one_sided, room1, room2;
    logic [NUM_THREADS-1:0] t_mask, n_mask;
    logic [AW-1:0]          lo_idx, hi_idx, top_idx;
    entry_t                 e_lo, e_hi, top;

    assign t_mask    = mask_q & bus.br_taken;
    assign n_mask    = mask_q & ~bus.br_taken;
    assign divergent = (t_mask != '0) && (n_mask != '0) && (bus.br_target != bus.br_fallthru);
    // One path is empty: only the reconvergence entry is needed.
    assign one_sided = (bus.br_target == bus.br_reconv) || (bus.br_fallthru == bus.br_reconv);
    assign room1     = depth_q < DW'(STACK_DEPTH);
    assign room2     = depth_q < DW'(STACK_DEPTH - 1);

    assign lo_idx  = AW'(depth_q);
    assign hi_idx  = AW'(depth_q + DW'(1));
    assign top_idx = AW'(depth_q - DW'(1));
    assign top     = stack_q[top_idx];

    assign e_lo = '{pc: bus.br_reconv,   mask: mask_q, rpc: rpc_q};
    assign e_hi = '{pc: bus.br_fallthru, mask: n_mask, rpc: bus.br_reconv};

    // NOTE: every variable gets a default before any branch so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        rpc_d      = rpc_q;
        depth_d    = depth_q;
        redir_d    = 1'b0;
        redir_pc_d = redir_pc_q;
        ovf_d      = ovf_q;
        push_lo    = 1'b0;
        push_hi    = 1'b0;
        do_pop     = 1'b0;

        case (state_q)
            S_RUN: begin
                if (bus.br_valid) begin
                    if (n_mask == '0) begin
                        redir_d    = 1'b1;
                        redir_pc_d = bus.br_target;
                    end else if (divergent && one_sided) begin
                        if (room1) begin
                            push_lo = 1'b1;
                            depth_d = depth_q + DW'(1);
                            rpc_d   = bus.br_reconv;
                            if (bus.br_target == bus.br_reconv) begin
                                mask_d = n_mask;
                            end else begin
                                mask_d     = t_mask;
                                redir_d    = 1'b1;
                                redir_pc_d = bus.br_target;
                            end
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (divergent) begin
                        if (room2) begin
                            push_lo    = 1'b1;
                            push_hi    = 1'b1;
                            depth_d    = depth_q + DW'(2);
                            rpc_d      = bus.br_reconv;
                            mask_d     = t_mask;
                            redir_d    = 1'b1;
                            redir_pc_d = bus.br_target;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end else if (bus.pc_valid && depth_q != '0 && bus.next_pc == rpc_q) begin
                    do_pop = 1'b1;
                end
            end
            S_CHAIN: do_pop = 1'b1;
            default: state_d = S_RUN;
        endcase

        // A popped entry whose pc is already the restored reconvergence point
        // has no code of its own to run, so keep popping with fetch held.
        if (do_pop) begin
            mask_d  = top.mask;
            rpc_d   = top.rpc;
            depth_d = depth_q - DW'(1);
            if (depth_d != '0 && top.pc == top.rpc) begin
                state_d = S_CHAIN;
            end else begin
                state_d    = S_RUN;
                redir_d    = 1'b1;
                redir_pc_d = top.pc;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            mask_q     <= '1;
            rpc_q      <= '0;
            depth_q    <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            rpc_q      <= rpc_d;
            depth_q    <= depth_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            ovf_q      <= ovf_d;
        end
    end

    // NOTE: stack storage is not reset; entries above depth are never read, so
    // leaving it out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push_lo) stack_q[lo_idx] <= e_lo;
        if (push_hi) stack_q[hi_idx] <= e_hi;
    end

    assign bus.active_mask    = mask_q;
    assign bus.redirect_valid = redir_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.stall          = (state_q == S_CHAIN);
    assign bus.depth          = depth_q;
    assign bus.overflow       = ovf_q;
endmodule

// File: tb/tb_simt_reconv_stack.sv
// Bench for simt_reconv_stack: directed scenarios plus randomized branch/retire
// traffic checked against a transaction-level stack model.
module tb_simt_reconv_stack;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    simt_reconv_stack_if #(.NUM_THREADS(4), .PC_WIDTH(16), .STACK_DEPTH(8)) bus ();
    simt_reconv_stack_if #(.NUM_THREADS(4), .PC_WIDTH(16), .STACK_DEPTH(2)) bus2 ();

    simt_reconv_stack #(.NUM_THREADS(4), .PC_WIDTH(16), .STACK_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    simt_reconv_stack #(.NUM_THREADS(4), .PC_WIDTH(16), .STACK_DEPTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    typedef struct {
        bit          rv;
        logic [15:0] pc;
        logic [3:0]  mask;
        int          depth;
        bit          ovf;
        bit          stall;
        int          stalls;
        bit          rv_in_stall;
    } obs_t;

    // Reference model: per instance, a plain array stack plus mask/rpc/overflow.
    logic [15:0] m_pc   [2][16];
    logic [3:0]  m_mk   [2][16];
    logic [15:0] m_rp   [2][16];
    int          m_dep  [2];
    logic [3:0]  m_mask [2];
    logic [15:0] m_rpc  [2];
    bit          m_ovf  [2];
    bit          e_rv;
    logic [15:0] e_pc;
    int          e_chain;

    function automatic int cap_of(input int k);
        return (k == 0) ? 8 : 2;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_dep[k] = 0; m_mask[k] = 4'b1111; m_rpc[k] = 16'd0; m_ovf[k] = 1'b0;
        end
    endfunction

    function automatic void model_push(input int k, input logic [15:0] pc, input logic [3:0] mk,
                                       input logic [15:0] rp);
        m_pc[k][m_dep[k]] = pc; m_mk[k][m_dep[k]] = mk; m_rp[k][m_dep[k]] = rp;
        m_dep[k]++;
    endfunction

    function automatic void model_branch(input int k, input logic [3:0] tk, input logic [15:0] tg,
                                         input logic [15:0] ft, input logic [15:0] rc);
        logic [3:0] t, n;
        int need;
        t = m_mask[k] & tk;
        n = m_mask[k] & ~tk;
        if (n == 4'b0000) begin e_rv = 1'b1; e_pc = tg; return; end
        if (t == 4'b0000 || tg == ft) return;
        need = (tg == rc || ft == rc) ? 1 : 2;
        if (m_dep[k] + need > cap_of(k)) begin m_ovf[k] = 1'b1; return; end
        model_push(k, rc, m_mask[k], m_rpc[k]);
        if (need == 2) model_push(k, ft, n, rc);
        m_rpc[k] = rc;
        if (tg == rc) m_mask[k] = n;
        else begin m_mask[k] = t; e_rv = 1'b1; e_pc = tg; end
    endfunction

    function automatic void model_retire(input int k, input logic [15:0] np);
        logic [15:0] popped;
        bit more;
        if (m_dep[k] == 0 || np != m_rpc[k]) return;
        do begin
            m_dep[k]--;
            popped    = m_pc[k][m_dep[k]];
            m_mask[k] = m_mk[k][m_dep[k]];
            m_rpc[k]  = m_rp[k][m_dep[k]];
            more      = (m_dep[k] > 0) && (popped == m_rpc[k]);
            if (more) e_chain++;
        end while (more);
        e_rv = 1'b1;
        e_pc = popped;
    endfunction

    task automatic drive(input int k, input bit bv, input logic [3:0] tk, input logic [15:0] tg,
                         input logic [15:0] ft, input logic [15:0] rc, input bit pv,
                         input logic [15:0] np);
        if (k == 0) begin
            bus.br_valid = bv; bus.br_taken = tk; bus.br_target = tg; bus.br_fallthru = ft;
            bus.br_reconv = rc; bus.pc_valid = pv; bus.next_pc = np;
        end else begin
            bus2.br_valid = bv; bus2.br_taken = tk; bus2.br_target = tg; bus2.br_fallthru = ft;
            bus2.br_reconv = rc; bus2.pc_valid = pv; bus2.next_pc = np;
        end
    endtask

    task automatic sample(input int k, inout obs_t o);
        if (k == 0) begin
            o.rv = bus.redirect_valid; o.pc = bus.redirect_pc; o.mask = bus.active_mask;
            o.depth = int'(bus.depth); o.ovf = bus.overflow; o.stall = bus.stall;
        end else begin
            o.rv = bus2.redirect_valid; o.pc = bus2.redirect_pc; o.mask = bus2.active_mask;
            o.depth = int'(bus2.depth); o.ovf = bus2.overflow; o.stall = bus2.stall;
        end
    endtask

    // Starts and ends on a falling edge; follows any chained pop with a cycle bound.
    task automatic apply(input int k, input bit bv, input logic [3:0] tk, input logic [15:0] tg,
                         input logic [15:0] ft, input logic [15:0] rc, input bit pv,
                         input logic [15:0] np, output obs_t o);
        e_rv = 1'b0; e_pc = 16'd0; e_chain = 0;
        if (bv) model_branch(k, tk, tg, ft, rc);
        else if (pv) model_retire(k, np);
        o.stalls = 0; o.rv_in_stall = 1'b0;
        drive(k, bv, tk, tg, ft, rc, pv, np);
        @(posedge clk); #1;
        drive(k, 1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sample(k, o);
            if (!o.stall) break;
            o.stalls++;
            if (o.rv) o.rv_in_stall = 1'b1;
            @(posedge clk);
        end
        if (o.stall) @(negedge clk);
    endtask

    task automatic branch(input int k, input logic [3:0] tk, input logic [15:0] tg,
                          input logic [15:0] ft, input logic [15:0] rc, output obs_t o);
        apply(k, 1'b1, tk, tg, ft, rc, 1'b0, 16'd0, o);
    endtask

    task automatic retire(input int k, input logic [15:0] np, output obs_t o);
        apply(k, 1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, np, o);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        checks++; if (bus.active_mask !== 4'b1111) begin errors++; $display("FAIL rst_mask got %b want 1111", bus.active_mask); end
        checks++; if (bus.depth !== 4'd0) begin errors++; $display("FAIL rst_depth got %0d want 0", bus.depth); end
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got %b want 0", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 16'd0) begin errors++; $display("FAIL rst_rpc got %0d want 0", bus.redirect_pc); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", bus.overflow); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", bus.stall); end
    endtask

    task automatic test_uniform();
        obs_t o;
        branch(0, 4'b1111, 16'd8, 16'd1, 16'd30, o);
        checks++; if ({o.rv, o.pc} !== {1'b1, 16'd8}) begin errors++; $display("FAIL uni_taken_redirect got %b/%0d want 1/8", o.rv, o.pc); end
        checks++; if (o.mask !== 4'b1111 || o.depth !== 0) begin errors++; $display("FAIL uni_taken_state got %b/%0d want 1111/0", o.mask, o.depth); end
        branch(0, 4'b0000, 16'd9, 16'd1, 16'd30, o);
        checks++; if (o.rv !== 1'b0) begin errors++; $display("FAIL uni_not_taken_rv got %b want 0", o.rv); end
        checks++; if (o.mask !== 4'b1111 || o.depth !== 0) begin errors++; $display("FAIL uni_not_taken_state got %b/%0d want 1111/0", o.mask, o.depth); end
    endtask

    task automatic test_general();
        obs_t o;
        branch(0, 4'b0010, 16'd10, 16'd3, 16'd20, o);
        checks++; if ({o.rv, o.pc} !== {1'b1, 16'd10}) begin errors++; $display("FAIL gen_redirect got %b/%0d want 1/10", o.rv, o.pc); end
        checks++; if (o.mask !== 4'b0010 || o.depth !== 2) begin errors++; $display("FAIL gen_state got %b/%0d want 0010/2", o.mask, o.depth); end
        retire(0, 16'd20, o);
        checks++; if ({o.rv, o.pc} !== {1'b1, 16'd3}) begin errors++; $display("FAIL gen_pop1_redirect got %b/%0d want 1/3", o.rv, o.pc); end
        checks++; if (o.mask !== 4'b1101 || o.depth !== 1) begin errors++; $display("FAIL gen_pop1_state got %b/%0d want 1101/1", o.mask, o.depth); end
        retire(0, 16'd20, o);
        checks++; if ({o.rv, o.pc} !== {1'b1, 16'd20}) begin errors++; $display("FAIL gen_pop2_redirect got %b/%0d want 1/20", o.rv, o.pc); end
        checks++; if (o.mask !== 4'b1111 || o.depth !== 0) begin errors++; $display("FAIL gen_pop2_state got %b/%0d want 1111/0", o.mask, o.depth); end
    endtask

    task automatic test_empty_paths();
        obs_t o;
        branch(0, 4'b0010, 16'd5, 16'd3, 16'd5, o);
        checks++; if (o.rv !== 1'b0) begin errors++; $display("FAIL empty_taken_rv got %b want 0", o.rv); end
        checks++; if (o.mask !== 4'b1101 || o.depth !== 1) begin errors++; $display("FAIL empty_taken_state got %b/%0d want 1101/1", o.mask, o.depth); end
        retire(0, 16'd5, o);
        checks++; if ({o.rv, o.pc, o.mask, o.depth} !== {1'b1, 16'd5, 4'b1111, 0}) begin errors++; $display("FAIL empty_taken_pop got %b/%0d/%b/%0d want 1/5/1111/0", o.rv, o.pc, o.mask, o.depth); end
        branch(0, 4'b0010, 16'd3, 16'd3, 16'd9, o);
        checks++; if ({o.rv, o.mask, o.depth} !== {1'b0, 4'b1111, 0}) begin errors++; $display("FAIL same_target_fallthru got %b/%b/%0d want 0/1111/0", o.rv, o.mask, o.depth); end
        branch(0, 4'b0010, 16'd7, 16'd4, 16'd4, o);
        checks++; if ({o.rv, o.pc, o.mask, o.depth} !== {1'b1, 16'd7, 4'b0010, 1}) begin errors++; $display("FAIL empty_else got %b/%0d/%b/%0d want 1/7/0010/1", o.rv, o.pc, o.mask, o.depth); end
        retire(0, 16'd4, o);
        checks++; if ({o.rv, o.pc, o.mask, o.depth} !== {1'b1, 16'd4, 4'b1111, 0}) begin errors++; $display("FAIL empty_else_pop got %b/%0d/%b/%0d want 1/4/1111/0", o.rv, o.pc, o.mask, o.depth); end
    endtask

    // Inner reconvergence shares PC 30 with the outer one: popping the inner
    // reconvergence entry chains straight into the outer else path (pc 3).
    task automatic test_nested();
        obs_t o;
        branch(0, 4'b0011, 16'd10, 16'd3, 16'd30, o);
        checks++; if ({o.rv, o.pc, o.mask, o.depth} !== {1'b1, 16'd10, 4'b0011, 2}) begin errors++; $display("FAIL nest_outer got %b/%0d/%b/%0d want 1/10/0011/2", o.rv, o.pc, o.mask, o.depth); end
        branch(0, 4'b0001, 16'd12, 16'd11, 16'd30, o);
        checks++; if ({o.rv, o.pc, o.mask, o.depth} !== {1'b1, 16'd12, 4'b0001, 4}) begin errors++; $display("FAIL nest_inner got %b/%0d/%b/%0d want 1/12/0001/4", o.rv, o.pc, o.mask, o.depth); end
        retire(0, 16'd30, o);
        checks++; if ({o.rv, o.pc, o.mask, o.depth} !== {1'b1, 16'd11, 4'b0010, 3}) begin errors++; $display("FAIL nest_inner_else got %b/%0d/%b/%0d want 1/11/0010/3", o.rv, o.pc, o.mask, o.depth); end
        retire(0, 16'd30, o);
        checks++; if (o.stalls !== 1 || o.rv_in_stall !== 1'b0) begin errors++; $display("FAIL nest_chain_stall got %0d cycles rv %b want 1 cycle rv 0", o.stalls, o.rv_in_stall); end
        checks++; if ({o.rv, o.pc, o.mask, o.depth, o.stall} !== {1'b1, 16'd3, 4'b1100, 1, 1'b0}) begin errors++; $display("FAIL nest_chain_end got %b/%0d/%b/%0d/%b want 1/3/1100/1/0", o.rv, o.pc, o.mask, o.depth, o.stall); end
        retire(0, 16'd30, o);
        checks++; if ({o.rv, o.pc, o.mask, o.depth} !== {1'b1, 16'd30, 4'b1111, 0}) begin errors++; $display("FAIL nest_final got %b/%0d/%b/%0d want 1/30/1111/0", o.rv, o.pc, o.mask, o.depth); end
    endtask

    task automatic test_priority();
        obs_t o;
        branch(0, 4'b0010, 16'd10, 16'd3, 16'd20, o);
        apply(0, 1'b1, 4'b0000, 16'd40, 16'd41, 16'd42, 1'b1, 16'd20, o);
        checks++; if ({o.rv, o.mask, o.depth} !== {1'b0, 4'b0010, 2}) begin errors++; $display("FAIL prio_branch_wins got %b/%b/%0d want 0/0010/2", o.rv, o.mask, o.depth); end
        retire(0, 16'd21, o);
        checks++; if ({o.rv, o.depth} !== {1'b0, 2}) begin errors++; $display("FAIL retire_other_pc got %b/%0d want 0/2", o.rv, o.depth); end
        retire(0, 16'd20, o);
        retire(0, 16'd20, o);
        checks++; if ({o.rv, o.pc, o.depth} !== {1'b1, 16'd20, 0}) begin errors++; $display("FAIL prio_drain got %b/%0d/%0d want 1/20/0", o.rv, o.pc, o.depth); end
        retire(0, 16'd0, o);
        checks++; if ({o.rv, o.mask, o.depth} !== {1'b0, 4'b1111, 0}) begin errors++; $display("FAIL underflow got %b/%b/%0d want 0/1111/0", o.rv, o.mask, o.depth); end
    endtask

    task automatic test_async_reset();
        obs_t o;
        branch(0, 4'b0010, 16'd10, 16'd3, 16'd20, o);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.active_mask !== 4'b1111 || bus.depth !== 4'd0) begin errors++; $display("FAIL async_rst_state got %b/%0d want 1111/0", bus.active_mask, bus.depth); end
        checks++; if ({bus.redirect_valid, bus.redirect_pc, bus.stall, bus.overflow} !== {1'b0, 16'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL async_rst_outputs got %b/%0d/%b/%b want 0/0/0/0", bus.redirect_valid, bus.redirect_pc, bus.stall, bus.overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_overflow();
        obs_t o;
        branch(1, 4'b0011, 16'd10, 16'd3, 16'd20, o);
        checks++; if ({o.rv, o.pc, o.mask, o.depth, o.ovf} !== {1'b1, 16'd10, 4'b0011, 2, 1'b0}) begin errors++; $display("FAIL ovf_first got %b/%0d/%b/%0d/%b want 1/10/0011/2/0", o.rv, o.pc, o.mask, o.depth, o.ovf); end
        branch(1, 4'b0001, 16'd12, 16'd11, 16'd30, o);
        checks++; if ({o.rv, o.mask, o.depth, o.ovf} !== {1'b0, 4'b0011, 2, 1'b1}) begin errors++; $display("FAIL ovf_refused got %b/%b/%0d/%b want 0/0011/2/1", o.rv, o.mask, o.depth, o.ovf); end
        retire(1, 16'd20, o);
        checks++; if ({o.rv, o.pc, o.mask, o.depth, o.ovf} !== {1'b1, 16'd3, 4'b1100, 1, 1'b1}) begin errors++; $display("FAIL ovf_pop1 got %b/%0d/%b/%0d/%b want 1/3/1100/1/1", o.rv, o.pc, o.mask, o.depth, o.ovf); end
        retire(1, 16'd20, o);
        checks++; if ({o.rv, o.pc, o.mask, o.depth, o.ovf} !== {1'b1, 16'd20, 4'b1111, 0, 1'b1}) begin errors++; $display("FAIL ovf_pop2 got %b/%0d/%b/%0d/%b want 1/20/1111/0/1", o.rv, o.pc, o.mask, o.depth, o.ovf); end
        do_reset();
        checks++; if (bus2.overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", bus2.overflow); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [3:0] tk;
        logic [15:0] tg, ft, rc, np;
        bit bv, pv;
        int sel;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            tk = 4'($urandom_range(0, 15));
            tg = 16'($urandom_range(0, 5));
            ft = 16'($urandom_range(0, 5));
            rc = 16'($urandom_range(0, 5));
            np = ($urandom_range(0, 3) != 0) ? m_rpc[0] : 16'($urandom_range(0, 5));
            bv = (sel < 5);
            pv = (sel >= 5 && sel < 9) || (sel < 5 && $urandom_range(0, 3) == 0);
            apply(0, bv, tk, tg, ft, rc, pv, np, o);
            checks++; if (o.rv !== e_rv || (e_rv && o.pc !== e_pc)) begin errors++; $display("FAIL rnd%0d_redirect got %b/%0d want %b/%0d", i, o.rv, o.pc, e_rv, e_pc); end
            checks++; if (o.mask !== m_mask[0] || o.depth !== m_dep[0]) begin errors++; $display("FAIL rnd%0d_state got %b/%0d want %b/%0d", i, o.mask, o.depth, m_mask[0], m_dep[0]); end
            checks++; if (o.ovf !== m_ovf[0]) begin errors++; $display("FAIL rnd%0d_ovf got %b want %b", i, o.ovf, m_ovf[0]); end
            checks++; if (o.stalls !== e_chain || o.rv_in_stall || o.stall) begin errors++; $display("FAIL rnd%0d_stall got %0d cycles rv %b want %0d cycles", i, o.stalls, o.rv_in_stall, e_chain); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        drive(0, 1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);
        drive(1, 1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_uniform();
        test_general();
        test_empty_paths();
        test_nested();
        test_priority();
        test_async_reset();
        test_overflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
